// File: rtl/scramble_pkg.sv
// Shared definitions for the colour-scramble control path: channel-select encodings,
// the preset permutation table and the sequencer state type.
package scramble_pkg;

    localparam int unsigned SEL_W     = 6;
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned N_PRESETS = 6;

    localparam logic [1:0] SRC_R    = 2'b00;
    localparam logic [1:0] SRC_G    = 2'b01;
    localparam logic [1:0] SRC_B    = 2'b10;
    localparam logic [1:0] SRC_ZERO = 2'b11;

    typedef logic [SEL_W-1:0] sel_t;

    localparam sel_t SEL_IDENTITY = {SRC_R, SRC_G, SRC_B};

    typedef enum logic [1:0] {
        MANUAL = 2'd0,
        AUTO   = 2'd1,
        FREEZE = 2'd2
    } scr_state_t;

    // Preset permutation table; out-of-range indices blank all channels.
    function automatic sel_t preset_sel(input logic [IDX_W-1:0] idx);
        case (idx)
            3'd0:    preset_sel = {SRC_R, SRC_G, SRC_B};
            3'd1:    preset_sel = {SRC_R, SRC_B, SRC_G};
            3'd2:    preset_sel = {SRC_G, SRC_R, SRC_B};
            3'd3:    preset_sel = {SRC_G, SRC_B, SRC_R};
            3'd4:    preset_sel = {SRC_B, SRC_R, SRC_G};
            3'd5:    preset_sel = {SRC_B, SRC_G, SRC_R};
            default: preset_sel = {SRC_ZERO, SRC_ZERO, SRC_ZERO};
        endcase
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        next_idx = (idx == IDX_W'(N_PRESETS - 1)) ? '0 : idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for quasi-static board inputs entering the pixel clock domain.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/scramble_sequencer.sv
// Chooses the channel-select word from the switches or a timed preset sequence and
// commits it to the scramble stage only on frame boundaries.
module scramble_sequencer
    import scramble_pkg::*;
#(
    parameter int unsigned FRAMES_PER_STEP = 60
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEL_W-1:0] sw_sel,
    input  logic             auto_en,
    input  logic             freeze,
    input  logic             step,
    input  logic             frame_start,
    output logic [SEL_W-1:0] sel,
    output logic [IDX_W-1:0] preset_idx,
    output logic             pending
);

    localparam int unsigned CNT_W = $clog2(FRAMES_PER_STEP) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);

    logic [SEL_W:0]     sync_q;
    sel_t               sw_s;
    logic               auto_s;
    scr_state_t         state, state_nxt;
    sel_t               shadow, sel_nxt;
    logic [IDX_W-1:0]   idx_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               advance;

    sync_2ff #(.WIDTH(SEL_W + 1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   ({auto_en, sw_sel}),
        .q   (sync_q)
    );

    assign sw_s   = sync_q[SEL_W-1:0];
    assign auto_s = sync_q[SEL_W];

    always_ff @(posedge clk) begin
        if (rst) state <= MANUAL;
        else     state <= state_nxt;
    end

    // Mode transitions, shadow selection and preset/frame-count bookkeeping.
    always_comb begin
        state_nxt = state;
        shadow    = sel;
        idx_nxt   = preset_idx;
        cnt_nxt   = cnt;
        advance   = 1'b0;
        case (state)
            MANUAL: begin
                shadow  = sw_s;
                cnt_nxt = '0;
                if (freeze) begin
                    state_nxt = FREEZE;
                end else if (auto_s) begin
                    state_nxt = AUTO;
                    idx_nxt   = '0;
                end
            end
            AUTO: begin
                shadow = preset_sel(preset_idx);
                if (freeze)       state_nxt = FREEZE;
                else if (!auto_s) state_nxt = MANUAL;
                // A step coinciding with the terminal count still advances only once.
                advance = step || (frame_start && (cnt == CNT_LAST));
                if (advance) begin
                    idx_nxt = next_idx(preset_idx);
                    cnt_nxt = '0;
                end else if (frame_start) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            FREEZE: begin
                shadow = sel;
                if (!freeze) state_nxt = auto_s ? AUTO : MANUAL;
            end
            default: state_nxt = MANUAL;
        endcase
        sel_nxt = sel;
        if (frame_start) sel_nxt = advance ? preset_sel(idx_nxt) : shadow;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel        <= SEL_IDENTITY;
            preset_idx <= '0;
            cnt        <= '0;
            pending    <= 1'b0;
        end else begin
            sel        <= sel_nxt;
            preset_idx <= idx_nxt;
            cnt        <= cnt_nxt;
            pending    <= (shadow != sel);
        end
    end

endmodule

// File: tb/tb_scramble_sequencer.sv
// Bench for scramble_sequencer: vector table, directed multi-frame sequences and
// randomized traffic checked against a mode-level reference model.
module tb_scramble_sequencer;

    localparam int FPS   = 3;
    localparam int M_MAN = 0;
    localparam int M_AUT = 1;
    localparam int M_FRZ = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] sw_sel;
    logic       auto_en;
    logic       freeze;
    logic       step;
    logic       frame_start;
    logic [5:0] sel;
    logic [2:0] preset_idx;
    logic       pending;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int         m_mode;
    int         m_idx;
    int         m_cnt;
    logic [5:0] m_sel, m_sw1, m_sw2;
    logic       m_a1, m_a2, m_pend;

    typedef struct {
        logic       rst;
        logic [5:0] sw;
        logic       fs;
        logic [5:0] esel;
        logic [2:0] eidx;
        logic       epend;
    } vec_t;

    vec_t vecs [11];

    scramble_sequencer #(.FRAMES_PER_STEP(FPS)) dut (
        .clk         (clk),
        .rst         (rst),
        .sw_sel      (sw_sel),
        .auto_en     (auto_en),
        .freeze      (freeze),
        .step        (step),
        .frame_start (frame_start),
        .sel         (sel),
        .preset_idx  (preset_idx),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] ref_preset(input int i);
        case (i)
            0:       return 6'b000110;
            1:       return 6'b001001;
            2:       return 6'b010010;
            3:       return 6'b011000;
            4:       return 6'b100001;
            default: return 6'b100100;
        endcase
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance model and DUT by one clock, then compare all outputs.
    task automatic tick();
        logic [5:0] shadow, n_sel;
        int         n_mode, n_idx, n_cnt;
        logic       n_pend, adv;
        shadow = (m_mode == M_MAN) ? m_sw2 : (m_mode == M_AUT) ? ref_preset(m_idx) : m_sel;
        n_mode = freeze ? M_FRZ : (m_a2 ? M_AUT : M_MAN);
        n_idx  = m_idx;
        n_cnt  = m_cnt;
        n_sel  = m_sel;
        adv    = 1'b0;
        if (m_mode == M_AUT) begin
            adv = step || (frame_start && m_cnt == FPS - 1);
            if (adv) begin
                n_idx = (m_idx + 1) % 6;
                n_cnt = 0;
            end else if (frame_start) begin
                n_cnt = m_cnt + 1;
            end
        end else if (m_mode == M_MAN) begin
            n_cnt = 0;
            if (n_mode == M_AUT) n_idx = 0;
        end
        if (frame_start) n_sel = adv ? ref_preset(n_idx) : shadow;
        n_pend = (shadow != m_sel);
        @(posedge clk);
        if (rst) begin
            m_mode = M_MAN; m_idx = 0; m_cnt = 0; m_sel = 6'b000110; m_pend = 1'b0;
            m_sw1 = '0; m_sw2 = '0; m_a1 = 1'b0; m_a2 = 1'b0;
        end else begin
            m_mode = n_mode; m_idx = n_idx; m_cnt = n_cnt; m_sel = n_sel; m_pend = n_pend;
            m_sw2 = m_sw1; m_sw1 = sw_sel; m_a2 = m_a1; m_a1 = auto_en;
        end
        #1;
        check("model", {6'd0, sel, preset_idx, pending}, {6'd0, m_sel, 3'(m_idx), m_pend});
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sw_sel = 6'b000110; auto_en = 1'b0; freeze = 1'b0; step = 1'b0; frame_start = 1'b0;
        m_mode = M_MAN; m_idx = 0; m_cnt = 0; m_sel = '0; m_pend = 1'b0;
        m_sw1 = '0; m_sw2 = '0; m_a1 = 1'b0; m_a2 = 1'b0;

        vecs[0]  = '{1'b1, 6'b000110, 1'b0, 6'b000110, 3'd0, 1'b0};
        vecs[1]  = '{1'b1, 6'b000110, 1'b0, 6'b000110, 3'd0, 1'b0};
        vecs[2]  = '{1'b0, 6'b000110, 1'b0, 6'b000110, 3'd0, 1'b1};
        vecs[3]  = '{1'b0, 6'b000110, 1'b0, 6'b000110, 3'd0, 1'b1};
        vecs[4]  = '{1'b0, 6'b000110, 1'b0, 6'b000110, 3'd0, 1'b0};
        vecs[5]  = '{1'b0, 6'b000110, 1'b1, 6'b000110, 3'd0, 1'b0};
        vecs[6]  = '{1'b0, 6'b100100, 1'b0, 6'b000110, 3'd0, 1'b0};
        vecs[7]  = '{1'b0, 6'b100100, 1'b0, 6'b000110, 3'd0, 1'b0};
        vecs[8]  = '{1'b0, 6'b100100, 1'b0, 6'b000110, 3'd0, 1'b1};
        vecs[9]  = '{1'b0, 6'b100100, 1'b1, 6'b100100, 3'd0, 1'b1};
        vecs[10] = '{1'b0, 6'b100100, 1'b0, 6'b100100, 3'd0, 1'b0};

        for (int i = 0; i < 11; i++) begin
            rst = vecs[i].rst; sw_sel = vecs[i].sw; frame_start = vecs[i].fs;
            tick();
            check($sformatf("vec%0d", i), {6'd0, sel, preset_idx, pending},
                  {6'd0, vecs[i].esel, vecs[i].eidx, vecs[i].epend});
        end
        frame_start = 1'b0;

        // Switch change without a frame boundary must not reach sel.
        sw_sel = 6'b011011;
        for (int i = 0; i < 100; i++) tick();
        check("hold_no_frame", {9'd0, sel, pending}, {9'd0, 6'b100100, 1'b1});
        pulse_fs();
        check("manual_apply", {10'd0, sel}, {10'd0, 6'b011011});

        // Auto mode: advance every FPS frames, wrap after the last preset.
        auto_en = 1'b1;
        repeat (4) tick();
        for (int k = 1; k <= 20; k++) begin
            pulse_fs();
            check($sformatf("auto_pulse%0d", k), {7'd0, sel, preset_idx},
                  {7'd0, ref_preset((k / 3) % 6), 3'((k / 3) % 6)});
            repeat (2) tick();
        end

        // Two lone steps, then a step coinciding with a frame boundary.
        repeat (2) begin
            step = 1'b1; tick(); step = 1'b0; tick();
        end
        check("step_to_2", {13'd0, preset_idx}, {13'd0, 3'd2});
        step = 1'b1;
        pulse_fs();
        step = 1'b0;
        check("step_fs_once", {7'd0, sel, preset_idx}, {7'd0, 6'b011000, 3'd3});
        tick();
        pulse_fs(); tick();
        pulse_fs(); tick();
        check("cnt_cleared", {13'd0, preset_idx}, {13'd0, 3'd3});
        pulse_fs(); tick();
        check("adv_to_4", {7'd0, sel, preset_idx}, {7'd0, 6'b100001, 3'd4});

        // Freeze ignores frames and steps, then resumes where it left off.
        freeze = 1'b1;
        repeat (2) tick();
        for (int k = 0; k < 10; k++) begin
            step = 1'b1;
            pulse_fs();
            step = 1'b0;
            tick();
            check($sformatf("frozen%0d", k), {7'd0, sel, preset_idx}, {7'd0, 6'b100001, 3'd4});
        end
        freeze = 1'b0;
        repeat (2) tick();
        pulse_fs(); tick();
        pulse_fs(); tick();
        check("resume_hold", {13'd0, preset_idx}, {13'd0, 3'd4});
        pulse_fs(); tick();
        check("resume_adv", {7'd0, sel, preset_idx}, {7'd0, 6'b100100, 3'd5});

        // Reset while a manual update is pending.
        auto_en = 1'b0;
        sw_sel  = 6'b010010;
        begin
            int waited = 0;
            while (pending !== 1'b1 && waited < 20) begin
                tick();
                waited++;
            end
            check("pending_wait", {15'd0, pending}, {15'd0, 1'b1});
        end
        rst = 1'b1; sw_sel = 6'b011000;
        tick();
        rst = 1'b0;
        check("reset_vals", {6'd0, sel, preset_idx, pending}, {6'd0, 6'b000110, 3'd0, 1'b0});
        repeat (3) tick();
        pulse_fs();
        check("post_reset_apply", {10'd0, sel}, {10'd0, 6'b011000});

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            rst         = ($urandom_range(0, 499) == 0);
            frame_start = ($urandom_range(0, 5) == 0);
            step        = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 39) == 0) freeze  = ~freeze;
            if ($urandom_range(0, 59) == 0) auto_en = ~auto_en;
            if ($urandom_range(0, 29) == 0) sw_sel  = 6'($urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scramble_sequencer.md
# scramble_sequencer

Control block for the colour-scramble datapath. It holds the 6-bit channel-select word (sel[5:4] red source, sel[3:2] green source, sel[1:0] blue source). Each field encodes 00 = source red, 01 = source green, 10 = source blue, 11 = zero. The block sources that word from the switches (manual mode) or from a preset table it steps through every N frames (auto mode). Updates are applied only on frame boundaries so a frame never shows two mappings. It sits between the board I/O and the scramble stage, in the pixel clock domain of the VGA pipeline.

## Interface
- FRAMES_PER_STEP, 60, frames between automatic preset advances; legal range 1..4095.
- clk  in  1  pixel/system clock.
- rst  in  1  synchronous, active-high reset.
- sw_sel  in  6  raw switch selection; asynchronous to clk.
- auto_en  in  1  raw switch; 1 requests auto mode; asynchronous.
- freeze  in  1  already synchronous level; 1 holds the current mapping.
- step  in  1  single-cycle pulse, already debounced; advances the preset.
- frame_start  in  1  single-cycle pulse at the start of vertical blanking.
- sel  out  6  active channel-select word to the scramble stage.
- preset_idx  out  3  current preset index, 0..5.
- pending  out  1  1 when the next-frame selection differs from sel.

## Operation
- sw_sel and auto_en each pass through a 2-flop synchronizer (sw_s, auto_s).
- The preset table holds six permutations:
  - 0 RGB = 000110
  - 1 RBG = 001001
  - 2 GRB = 010010
  - 3 GBR = 011000
  - 4 BRG = 100001
  - 5 BGR = 100100
- The FSM has three states: MANUAL, AUTO, FREEZE. Priority is freeze > auto_s.
  - MANUAL→AUTO when auto_s=1 and freeze=0.
  - AUTO→MANUAL when auto_s=0.
  - MANUAL or AUTO→FREEZE when freeze=1.
  - FREEZE→AUTO or MANUAL when freeze=0, chosen by auto_s.
- The shadow selection is combinational from the registered state:
  - MANUAL: shadow = sw_s.
  - AUTO: shadow = PRESET[preset_idx].
  - FREEZE: shadow = sel.
- sel loads shadow only in a cycle with frame_start=1. Otherwise sel holds.
- The frame counter cnt has width clog2(FRAMES_PER_STEP)+1.
  - AUTO, frame_start, cnt==FRAMES_PER_STEP-1: cnt←0, preset_idx←(idx==5)?0:idx+1, and sel←PRESET[new idx] in the same update.
  - AUTO, frame_start, otherwise: cnt←cnt+1.
  - FREEZE: cnt and preset_idx hold.
  - MANUAL: cnt holds at 0 and preset_idx holds.
- Behaviour of step:
  - In AUTO, step advances preset_idx by one with wrap and sets cnt←0. The new preset is applied at the next frame_start.
  - step together with frame_start in the same cycle advances preset_idx exactly once (not twice), applies the advanced preset at that frame_start, and sets cnt←0.
  - step is ignored in MANUAL and in FREEZE.
- Entry into AUTO from MANUAL: preset_idx←0, cnt←0.
- Return to AUTO from FREEZE: preset_idx and cnt are kept.
- pending = (shadow != sel), registered.
- With FRAMES_PER_STEP=1, the preset advances on every frame_start.

## Timing
- Reset values:
  - sel=000110 (identity, not all-zero).
  - preset_idx=0, pending=0, cnt=0.
  - State MANUAL; synchronizer flops 0.
- A change on sw_sel or auto_en reaches sw_s/auto_s after 2 clk. The state changes on the following edge.
- sel changes on the clk edge that samples frame_start=1, so it is visible in the cycle after the pulse. It never changes in any other cycle.
- Latency from a sw_sel change to sel: 2 clk of sync plus the wait to the next frame_start.
- pending lags shadow by 1 clk.
- A state transition and frame_start in the same cycle: the frame uses the shadow from the pre-transition state.
- rst asserted mid-frame forces all reset values on the next edge. The pending update is discarded.

## Structure
- Package scramble_pkg holds:
  - the sel field encodings (SRC_R=2'b00, SRC_G=2'b01, SRC_B=2'b10, SRC_ZERO=2'b11);
  - the PRESET table constant and N_PRESETS=6;
  - the state enum scr_state_t {MANUAL, AUTO, FREEZE}.
- One sub-module, sync_2ff, parameterized by width. It is instantiated once at 7 bits for sw_sel and auto_en.

## Test plan
- Reset release, then frame_start: sel=000110, preset_idx=0, pending=0.
- MANUAL, sw_sel=100100 held, no frame_start for 100 clk: sel stays 000110 and pending=1 by clk 4. At the next frame_start, sel=100100 in the following cycle and pending returns to 0.
- FRAMES_PER_STEP=3, auto_en=1, 20 frame_start pulses: preset_idx goes 0→1 at the 3rd pulse and wraps 5→0 at the 18th. sel matches PRESET[idx] each time.
- AUTO, step coincident with frame_start at idx=2: idx=3 (not 4), sel=011000 after that pulse, cnt=0.
- AUTO at idx=4, then freeze=1 for 10 frames with step pulses: sel and idx unchanged. After freeze=0 the sequence resumes from idx=4.
- rst pulse while pending=1 in MANUAL: the next frame_start after reset drives sel from sw_s, not the stale pre-reset shadow. All outputs read reset values in the cycle after rst.
